rc_channel_decoder: RTL and testbench
=====================================

// Module: rc_channel_decoder
// PURPOSE
//  Stage directly after the RC pulse-width detector. Takes each measured pulse width,
//  validates it, tracks link lock/failsafe, and emits a signed, centred, clamped channel
//  value on a valid/ready stream for the servo/mixer logic. Width 0 (low timeout) and
//  16'hFFFF (stuck high) from the detector are always treated as bad pulses.
// PARAMETERS
//  MIN_TICKS      1600    shortest good pulse width, in ticks (inclusive)
//  MAX_TICKS      4400    longest good pulse width, in ticks (inclusive)
//  CENTER_TICKS   3000    width that maps to output 0
//  HALF_SPAN      1000    output clamp magnitude: o_value stays within +/-HALF_SPAN
//  LOCK_COUNT     4       consecutive good pulses needed to enter LOCKED
//  MISS_LIMIT     3       consecutive bad pulses in LOCKED that force FAILSAFE
//  TIMEOUT_TICKS  100000  clocks with no i_pw_stb that force FAILSAFE
//  FAILSAFE_VALUE 0       o_value emitted when FAILSAFE is entered
// PORTS
//  i_clk          in   1   clock
//  i_rst_n        in   1   asynchronous reset, active low
//  i_pulse_width  in  16   measured width, in ticks, from the detector
//  i_pw_stb       in   1   one-cycle strobe; i_pulse_width is valid in this cycle
//  o_valid        out  1   o_value holds a new sample
//  i_ready        in   1   consumer accepts the sample when o_valid && i_ready
//  o_value        out 16   signed channel value, two's complement
//  o_state        out  2   0=NOSIG 1=ACQ 2=LOCKED 3=FAILSAFE
//  o_failsafe     out  1   high exactly when o_state==FAILSAFE
//  o_overrun      out  1   sticky; set when an unaccepted sample is overwritten
// BEHAVIOUR
//  Reset: state NOSIG; o_valid=0, o_value=0, o_failsafe=0, o_overrun=0.
//    Lock counter, miss counter and timeout counter all clear.
//  Good pulse: MIN_TICKS <= w <= MAX_TICKS. Every other width is a bad pulse.
//  Conversion: d = w - CENTER_TICKS (17-bit signed), saturated to +/-HALF_SPAN,
//    then truncated to 16 bits.
//  FSM, evaluated only on cycles with i_pw_stb=1 or a timeout:
//    NOSIG:    good -> ACQ with lock=1. Bad pulse or timeout -> stay in NOSIG.
//    ACQ:      good -> lock++; at lock==LOCK_COUNT -> LOCKED.
//              Bad pulse -> NOSIG with lock=0. Timeout -> NOSIG.
//    LOCKED:   good -> emit the converted value; miss=0.
//              Bad pulse -> miss++ and re-emit the last good value;
//              at miss==MISS_LIMIT -> FAILSAFE and emit FAILSAFE_VALUE instead.
//              Timeout -> FAILSAFE and emit FAILSAFE_VALUE.
//    FAILSAFE: good -> lock++; at lock==LOCK_COUNT -> LOCKED. Bad pulse -> lock=0.
//              Timeout -> stay in FAILSAFE, emit nothing.
//  The pulse that reaches LOCK_COUNT is itself emitted.
//  Timeout counter: clears on every i_pw_stb and counts otherwise. At TIMEOUT_TICKS it
//    fires one timeout event, then clears. Strobe and terminal count in the same cycle:
//    the strobe wins and no timeout fires.
//  Latency: i_pw_stb in cycle N -> o_valid and o_value registered in cycle N+1.
//  Handshake: o_valid holds, with o_value stable, until o_valid&&i_ready.
//    A new emit while o_valid=1 and i_ready=0 replaces o_value, keeps o_valid=1 and
//    sets o_overrun.
//    Emit in the same cycle as an acceptance: o_valid stays 1 with the new data,
//    and no overrun is flagged.
//  Asynchronous reset mid-stream drops any pending sample immediately.
// CONFIGURATION
//  RC_DEC_MEDIAN3_EN defined:
//    - Good pulses pass through a 3-tap median before conversion. Latency becomes N+2.
//    - On the transition into LOCKED, all three taps preload with the locking width.
//    - Bad pulses never enter the taps.
//  Not defined: no filter; latency is N+1 as above.
// STRUCTURE
//  Package rc_pkg: rc_state_e enum (NOSIG/ACQ/LOCKED/FAILSAFE) and
//    localparam RC_PW_W=16. Shared with the detector and downstream mixer.
//  Sub-module rc_median3: 3-tap median with load/preload inputs and a registered
//    output; instantiated only under RC_DEC_MEDIAN3_EN.
// TESTING
//  1. Reset, then 4 strobes of w=3000 -> state ACQ,ACQ,ACQ,LOCKED; one o_valid, value 0.
//  2. LOCKED with i_ready=1, w=3500 -> o_value=500 at N+1;
//     w=4400 -> 1000; w=1600 -> -1000 (clamp).
//  3. LOCKED, last good=200; widths 0, 16'hFFFF, 5000 ->
//     emits 200, 200, then FAILSAFE_VALUE; o_failsafe=1.
//  4. LOCKED, no strobe for 100000 clocks -> FAILSAFE plus one emit of FAILSAFE_VALUE;
//     4 good pulses -> LOCKED.
//  5. i_ready=0, two good pulses 3100 then 3200 -> o_value=200, o_overrun=1;
//     assert i_ready -> o_valid drops the next cycle.
//  6. MEDIAN3_EN: LOCKED at 3000; pulses 3000, 4000, 3100 -> outputs 0, 0, 100 at N+2.

Source files
------------

// File: rtl/rc_pkg.sv
// Shared RC channel types: link state encoding, pulse-width bus width and a median helper.
// Used by the pulse detector, the channel decoder and the downstream mixer.
package rc_pkg;

    localparam int RC_PW_W = 16;

    typedef enum logic [1:0] {
        RC_NOSIG    = 2'd0,
        RC_ACQ      = 2'd1,
        RC_LOCKED   = 2'd2,
        RC_FAILSAFE = 2'd3
    } rc_state_e;

    typedef enum logic [1:0] {
        EMIT_CONV = 2'd0,
        EMIT_LAST = 2'd1,
        EMIT_FS   = 2'd2
    } rc_emit_e;

    function automatic logic [RC_PW_W-1:0] med3(input logic [RC_PW_W-1:0] a,
                                                input logic [RC_PW_W-1:0] b,
                                                input logic [RC_PW_W-1:0] c);
        logic [RC_PW_W-1:0] lo;
        logic [RC_PW_W-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo) begin
            med3 = lo;
        end else if (c > hi) begin
            med3 = hi;
        end else begin
            med3 = c;
        end
    endfunction

endpackage

// File: rtl/rc_median3.sv
// 3-tap median over the incoming width and the two previous good widths, registered output.
// preload fills every tap with din so the filter starts settled.
module rc_median3
    import rc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               preload,
    input  logic [RC_PW_W-1:0] din,
    output logic [RC_PW_W-1:0] dout
);

    logic [RC_PW_W-1:0] tap0_r;
    logic [RC_PW_W-1:0] tap1_r;
    logic [RC_PW_W-1:0] med_r;

    // Tap history and median result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap0_r <= {RC_PW_W{1'b0}};
            tap1_r <= {RC_PW_W{1'b0}};
            med_r  <= {RC_PW_W{1'b0}};
        end else if (preload) begin
            tap0_r <= din;
            tap1_r <= din;
            med_r  <= din;
        end else if (load) begin
            tap0_r <= din;
            tap1_r <= tap0_r;
            med_r  <= med3(din, tap0_r, tap1_r);
        end
    end

    assign dout = med_r;

endmodule

// File: rtl/rc_channel_decoder.sv
// RC channel decoder: validates detector pulse widths, tracks lock/failsafe and streams a
// centred, clamped signed value. Define RC_DEC_MEDIAN3_EN to add a 3-tap median filter.
module rc_channel_decoder
    import rc_pkg::*;
#(
    parameter int                 MIN_TICKS      = 1600,
    parameter int                 MAX_TICKS      = 4400,
    parameter int                 CENTER_TICKS   = 3000,
    parameter int                 HALF_SPAN      = 1000,
    parameter int                 LOCK_COUNT     = 4,
    parameter int                 MISS_LIMIT     = 3,
    parameter int                 TIMEOUT_TICKS  = 100000,
    parameter logic [RC_PW_W-1:0] FAILSAFE_VALUE = 16'h0000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [RC_PW_W-1:0] i_pulse_width,
    input  logic               i_pw_stb,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [RC_PW_W-1:0] o_value,
    output logic [1:0]         o_state,
    output logic               o_failsafe,
    output logic               o_overrun
);

    localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam int DW     = RC_PW_W + 1;
    localparam logic signed [DW-1:0] CENTER_S = DW'(CENTER_TICKS);
    localparam logic signed [DW-1:0] SPAN_S   = DW'(HALF_SPAN);

    rc_state_e          state_r, state_nx_s;
    logic [LOCK_W-1:0]  lock_r, lock_nx_s;
    logic [MISS_W-1:0]  miss_r, miss_nx_s;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               failsafe_r, valid_r, overrun_r;
    logic [RC_PW_W-1:0] value_r, last_good_r, value_s, conv_w_s;
    logic               timeout_s, pulse_good_s, pulse_bad_s, lock_hit_s, miss_hit_s;
    logic               emit_s, emit_en_s;
    rc_emit_e           kind_s, kind_en_s;

    function automatic logic [RC_PW_W-1:0] to_value(input logic [RC_PW_W-1:0] w);
        logic signed [DW-1:0] d;
        logic signed [DW-1:0] q;
        d = $signed({1'b0, w}) - CENTER_S;
        if (d > SPAN_S) begin
            q = SPAN_S;
        end else if (d < -SPAN_S) begin
            q = -SPAN_S;
        end else begin
            q = d;
        end
        return q[RC_PW_W-1:0];
    endfunction

    assign pulse_good_s = i_pw_stb && (i_pulse_width >= RC_PW_W'(MIN_TICKS))
                                   && (i_pulse_width <= RC_PW_W'(MAX_TICKS));
    assign pulse_bad_s  = i_pw_stb && !pulse_good_s;
    assign timeout_s    = !i_pw_stb && (tmo_cnt_r == TMO_W'(TIMEOUT_TICKS - 1));
    assign lock_hit_s   = (lock_r + LOCK_W'(1)) == LOCK_W'(LOCK_COUNT);
    assign miss_hit_s   = (miss_r + MISS_W'(1)) == MISS_W'(MISS_LIMIT);

    // Link FSM: next state, counters and what to emit for this pulse or timeout
    always_comb begin
        state_nx_s = state_r;
        lock_nx_s  = lock_r;
        miss_nx_s  = miss_r;
        emit_s     = 1'b0;
        kind_s     = EMIT_CONV;
        if (i_pw_stb || timeout_s) begin
            case (state_r)
                RC_NOSIG: begin
                    if (pulse_good_s) begin
                        state_nx_s = RC_ACQ;
                        lock_nx_s  = LOCK_W'(1);
                    end else begin
                        lock_nx_s  = LOCK_W'(0);
                    end
                end
                RC_ACQ, RC_FAILSAFE: begin
                    if (pulse_good_s && lock_hit_s) begin
                        state_nx_s = RC_LOCKED;
                        lock_nx_s  = LOCK_W'(0);
                        miss_nx_s  = MISS_W'(0);
                        emit_s     = 1'b1;
                    end else if (pulse_good_s) begin
                        lock_nx_s  = lock_r + LOCK_W'(1);
                    end else if (state_r == RC_ACQ) begin
                        state_nx_s = RC_NOSIG;
                        lock_nx_s  = LOCK_W'(0);
                    end else if (pulse_bad_s) begin
                        lock_nx_s  = LOCK_W'(0);
                    end else begin
                        lock_nx_s  = lock_r;
                    end
                end
                RC_LOCKED: begin
                    if (pulse_good_s) begin
                        emit_s     = 1'b1;
                        miss_nx_s  = MISS_W'(0);
                    end else if (pulse_bad_s && !miss_hit_s) begin
                        emit_s     = 1'b1;
                        kind_s     = EMIT_LAST;
                        miss_nx_s  = miss_r + MISS_W'(1);
                    end else begin
                        // miss limit reached or link timed out
                        state_nx_s = RC_FAILSAFE;
                        emit_s     = 1'b1;
                        kind_s     = EMIT_FS;
                        lock_nx_s  = LOCK_W'(0);
                        miss_nx_s  = MISS_W'(0);
                    end
                end
                default: begin
                    state_nx_s = RC_NOSIG;
                    lock_nx_s  = LOCK_W'(0);
                    miss_nx_s  = MISS_W'(0);
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

`ifdef RC_DEC_MEDIAN3_EN
    logic     emit_d_r;
    rc_emit_e kind_d_r;
    logic     load_s, preload_s;

    assign preload_s = emit_s && (kind_s == EMIT_CONV) && (state_r != RC_LOCKED);
    assign load_s    = emit_s && (kind_s == EMIT_CONV) && (state_r == RC_LOCKED);

    rc_median3 u_median3 (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (load_s),
        .preload (preload_s),
        .din     (i_pulse_width),
        .dout    (conv_w_s)
    );

    // Delay the emit decision to line up with the registered median
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            emit_d_r <= 1'b0;
            kind_d_r <= EMIT_CONV;
        end else begin
            emit_d_r <= emit_s;
            kind_d_r <= kind_s;
        end
    end

    assign emit_en_s = emit_d_r;
    assign kind_en_s = kind_d_r;
`else
    assign emit_en_s = emit_s;
    assign kind_en_s = kind_s;
    assign conv_w_s  = i_pulse_width;
`endif

    // Select the value for the outgoing sample
    always_comb begin
        value_s = FAILSAFE_VALUE;
        case (kind_en_s)
            EMIT_CONV: value_s = to_value(conv_w_s);
            EMIT_LAST: value_s = last_good_r;
            EMIT_FS:   value_s = FAILSAFE_VALUE;
            default:   value_s = FAILSAFE_VALUE;
        endcase
    end

    // Link state, counters and the timeout timer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= RC_NOSIG;
            lock_r     <= LOCK_W'(0);
            miss_r     <= MISS_W'(0);
            tmo_cnt_r  <= TMO_W'(0);
            failsafe_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            lock_r     <= lock_nx_s;
            miss_r     <= miss_nx_s;
            failsafe_r <= (state_nx_s == RC_FAILSAFE);
            if (i_pw_stb || timeout_s) begin
                tmo_cnt_r <= TMO_W'(0);
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
        end
    end

    // Output stream register with valid/ready hold and sticky overrun
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r     <= 1'b0;
            value_r     <= {RC_PW_W{1'b0}};
            overrun_r   <= 1'b0;
            last_good_r <= {RC_PW_W{1'b0}};
        end else begin
            if (emit_en_s) begin
                valid_r <= 1'b1;
                value_r <= value_s;
                if (valid_r && !i_ready) begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && i_ready) begin
                valid_r <= 1'b0;
            end
            if (emit_en_s && (kind_en_s == EMIT_CONV)) begin
                last_good_r <= value_s;
            end
        end
    end

    assign o_valid    = valid_r;
    assign o_value    = value_r;
    assign o_state    = state_r;
    assign o_failsafe = failsafe_r;
    assign o_overrun  = overrun_r;

endmodule

// File: tb/tb_rc_channel_decoder.sv
// Self-checking bench for rc_channel_decoder: directed scenarios with literal expectations,
// then randomized pulses, all compared every cycle against a behavioural link model.
module tb_rc_channel_decoder;

    localparam int TMO = 300;
`ifdef RC_DEC_MEDIAN3_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int S_NOSIG  = 0;
    localparam int S_ACQ    = 1;
    localparam int S_LOCKED = 2;
    localparam int S_FS     = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pw    = 16'h0000;
    logic        stb   = 1'b0;
    logic        ready = 1'b0;
    logic        o_valid;
    logic [15:0] o_value;
    logic [1:0]  o_state;
    logic        o_failsafe;
    logic        o_overrun;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model of the link
    int m_state, m_lock, m_miss, m_last, m_idle, m_value, m_pend_val;
    int taps[3];
    bit m_valid, m_ovr, m_pend;

    always #5 clk = ~clk;

    rc_channel_decoder #(.TIMEOUT_TICKS(TMO)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pulse_width (pw),
        .i_pw_stb      (stb),
        .o_valid       (o_valid),
        .i_ready       (ready),
        .o_value       (o_value),
        .o_state       (o_state),
        .o_failsafe    (o_failsafe),
        .o_overrun     (o_overrun)
    );

    function automatic int conv_m(input int w);
        int d;
        d = w - 3000;
        if (d > 1000) return 1000;
        if (d < -1000) return -1000;
        return d;
    endfunction

    function automatic int med_m(input int a, input int b, input int c);
        int hi, lo;
        hi = (a > b) ? a : b;
        hi = (hi > c) ? hi : c;
        lo = (a < b) ? a : b;
        lo = (lo < c) ? lo : c;
        return a + b + c - hi - lo;
    endfunction

    task automatic model_reset();
        m_state = S_NOSIG; m_lock = 0; m_miss = 0; m_last = 0; m_idle = 0;
        m_value = 0; m_valid = 0; m_ovr = 0; m_pend = 0; m_pend_val = 0;
        taps = '{0, 0, 0};
    endtask

    task automatic enter_locked(input int w, output int val);
        m_state = S_LOCKED; m_lock = 0; m_miss = 0;
        taps = '{w, w, w};
        val = conv_m(w);
        m_last = val;
    endtask

    // predicts the outputs after the coming clock edge given this cycle's inputs
    task automatic model_step(input logic s, input logic [15:0] w, input logic r);
        int  wi, val, due_val;
        bit  good, tmo, emit, due;
        wi = int'(w);
        good = s && (wi >= 1600) && (wi <= 4400);
        tmo = 0; emit = 0; val = 0;
        if (s) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TMO) begin tmo = 1; m_idle = 0; end
        end
        if (s || tmo) begin
            case (m_state)
                S_NOSIG: if (good) begin m_state = S_ACQ; m_lock = 1; end
                S_ACQ, S_FS: begin
                    if (good) begin
                        m_lock++;
                        if (m_lock == 4) begin enter_locked(wi, val); emit = 1; end
                    end else if (m_state == S_ACQ) begin
                        m_state = S_NOSIG; m_lock = 0;
                    end else if (s) begin
                        m_lock = 0;
                    end
                end
                default: begin
                    emit = 1;
                    if (good) begin
                        taps[2] = taps[1]; taps[1] = taps[0]; taps[0] = wi;
                        val = conv_m((LAT == 2) ? med_m(taps[0], taps[1], taps[2]) : wi);
                        m_last = val; m_miss = 0;
                    end else if (s && m_miss < 2) begin
                        m_miss++; val = m_last;
                    end else begin
                        m_state = S_FS; m_lock = 0; m_miss = 0; val = 0;
                    end
                end
            endcase
        end
        if (LAT == 2) begin
            due = m_pend; due_val = m_pend_val; m_pend = emit; m_pend_val = val;
        end else begin
            due = emit; due_val = val;
        end
        if (due) begin
            if (m_valid && !r) m_ovr = 1;
            m_valid = 1; m_value = due_val;
        end else if (m_valid && r) begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("state", int'(o_state), m_state);
        chk("failsafe", int'(o_failsafe), (m_state == S_FS) ? 1 : 0);
        chk("valid", int'(o_valid), int'(m_valid));
        chk("overrun", int'(o_overrun), int'(m_ovr));
        if (m_valid) chk("value", int'($signed(o_value)), m_value);
    endtask

    // drive one cycle of inputs, then check the outputs after the edge
    task automatic tick(input logic s, input logic [15:0] w, input logic r);
        stb = s; pw = w; ready = r;
        model_step(s, w, r);
        @(negedge clk);
        compare_all();
    endtask

    task automatic settle(input logic r);
        if (LAT == 2) tick(1'b0, 16'h0000, r);
    endtask

    // the median build needs the width twice before it dominates the taps
    task automatic pulse_chk(input logic [15:0] w, input logic r, input int exp);
        if (LAT == 2) tick(1'b1, w, r);
        tick(1'b1, w, r);
        settle(r);
        chk("pulse_value", int'($signed(o_value)), exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stb = 1'b0; pw = 16'h0000; ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_state", int'(o_state), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_value", int'(o_value), 0);
        chk("rst_failsafe", int'(o_failsafe), 0);
        chk("rst_overrun", int'(o_overrun), 0);
    endtask

    function automatic logic [15:0] rnd_width();
        int k;
        int b;
        k = $urandom_range(0, 9);
        b = $urandom_range(0, 3);
        case (k)
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return (b == 0) ? 16'd1599 : (b == 1) ? 16'd1600 : (b == 2) ? 16'd4400 : 16'd4401;
            3: return 16'($urandom);
            default: return 16'($urandom_range(1600, 4400));
        endcase
    endfunction

    initial begin
        do_reset();

        // acquisition and lock on four centred pulses
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 16'd3000, 1'b0);
            chk("acq_state", int'(o_state), 1);
        end
        tick(1'b1, 16'd3000, 1'b0);
        chk("lock_state", int'(o_state), 2);
        settle(1'b0);
        chk("lock_valid", int'(o_valid), 1);
        chk("lock_value", int'($signed(o_value)), 0);
        tick(1'b0, 16'h0000, 1'b1);
        chk("lock_accept", int'(o_valid), 0);

        // conversion and clamping
        pulse_chk(16'd3500, 1'b1, 500);
        pulse_chk(16'd4400, 1'b1, 1000);
        pulse_chk(16'd1600, 1'b1, -1000);

        // bad pulses re-emit the last good value, then failsafe
        pulse_chk(16'd3200, 1'b1, 200);
        tick(1'b1, 16'h0000, 1'b1); settle(1'b1);
        chk("miss1_value", int'($signed(o_value)), 200);
        tick(1'b1, 16'hFFFF, 1'b1); settle(1'b1);
        chk("miss2_value", int'($signed(o_value)), 200);
        tick(1'b1, 16'd5000, 1'b1); settle(1'b1);
        chk("miss3_value", int'($signed(o_value)), 0);
        chk("miss3_failsafe", int'(o_failsafe), 1);

        // relock, strobe on the terminal count, then a real timeout
        repeat (4) tick(1'b1, 16'd3000, 1'b1);
        chk("relock_state", int'(o_state), 2);
        tick(1'b1, 16'd3000, 1'b1);
        repeat (TMO - 1) tick(1'b0, 16'h0000, 1'b1);
        tick(1'b1, 16'd3000, 1'b1);
        chk("strobe_wins_state", int'(o_state), 2);
        for (int k = 0; k < TMO + 1; k++) tick(1'b0, 16'h0000, (k < 3) ? 1'b1 : 1'b0);
        chk("tmo_state", int'(o_state), 3);
        chk("tmo_failsafe", int'(o_failsafe), 1);
        chk("tmo_valid", int'(o_valid), 1);
        chk("tmo_value", int'($signed(o_value)), 0);
        chk("tmo_overrun", int'(o_overrun), 0);
        repeat (4) tick(1'b1, 16'd3000, 1'b1);
        chk("tmo_relock", int'(o_state), 2);
        repeat (2) tick(1'b0, 16'h0000, 1'b1);

        // overrun while the consumer stalls
        tick(1'b1, 16'd3100, 1'b0);
        pulse_chk(16'd3200, 1'b0, 200);
        chk("ovr_flag", int'(o_overrun), 1);
        tick(1'b0, 16'h0000, 1'b1);
        chk("ovr_drain", int'(o_valid), 0);

        // asynchronous reset drops a pending sample at once
        tick(1'b1, 16'd3000, 1'b0);
        settle(1'b0);
        #2 rst_n = 1'b0;
        #1 chk("async_drop", int'(o_valid), 0);
        do_reset();

`ifdef RC_DEC_MEDIAN3_EN
        repeat (4) tick(1'b1, 16'd3000, 1'b1);
        settle(1'b1);
        tick(1'b1, 16'd3000, 1'b1);
        tick(1'b1, 16'd4000, 1'b1);
        chk("med_a", int'($signed(o_value)), 0);
        tick(1'b1, 16'd3100, 1'b1);
        chk("med_b", int'($signed(o_value)), 0);
        tick(1'b0, 16'h0000, 1'b1);
        chk("med_c", int'($signed(o_value)), 100);
        do_reset();
`endif

        // randomized pulses, gaps, stalls and occasional timeouts
        for (int it = 0; it < 1200; it++) begin
            int gap;
            gap = $urandom_range(0, 4);
            if ($urandom_range(0, 99) == 0) gap = TMO + 20;
            for (int g = 0; g < gap; g++) tick(1'b0, 16'($urandom), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
            tick(1'b1, rnd_width(), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
